// File: rtl/crc8_frame_serializer.sv
// Frame serializer for a bit-serial CRC-8 engine: payload bytes out MSB-first, then the engine's CRC byte.
// Stalls in LOAD with DIN_READY=1 until DIN_VALID; optional shadow CRC check under CRC8SER_SELFCHECK_EN.
module crc8_frame_serializer #(
  parameter int LEN_W   = 8,
  parameter int BIT_DIV = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [LEN_W-1:0] LEN,
  input  logic [7:0]       DIN,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  input  logic [7:0]       CRC_IN,
  output logic             CRC_BITVAL,
  output logic             CRC_BITSTRB,
  output logic             CRC_ENABLE,
  output logic             CRC_CLEAR,
  output logic             TXD,
  output logic             TX_VALID,
  output logic             BUSY,
  output logic             DONE,
  output logic             CRC_ERR
);

  localparam int DW = (BIT_DIV > 2) ? $clog2(BIT_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(BIT_DIV / 2);

  typedef enum logic [2:0] {IDLE, CLR, LOAD, SHIFT, LATCH, CSHIFT, FIN} state_t;

  state_t           state_q, state_n;
  logic [DW-1:0]    div_q, div_n;
  logic [2:0]       bit_q, bit_n;
  logic [LEN_W-1:0] cnt_q, cnt_n;
  logic [7:0]       sreg_q, sreg_n;

  logic din_ready_n, crc_bitval_n, crc_bitstrb_n, crc_enable_n, crc_clear_n;
  logic txd_n, tx_valid_n, busy_n, done_n;

  always_comb begin
    state_n = state_q;
    div_n   = div_q;
    bit_n   = bit_q;
    cnt_n   = cnt_q;
    sreg_n  = sreg_q;
    case (state_q)
      IDLE: if (START) begin
        state_n = CLR;
        cnt_n   = LEN;
      end
      CLR: state_n = (cnt_q != '0) ? LOAD : LATCH;
      LOAD: if (DIN_VALID && DIN_READY) begin
        sreg_n  = DIN;
        bit_n   = 3'd7;
        div_n   = '0;
        state_n = SHIFT;
      end
      SHIFT, CSHIFT: begin
        if (div_q == DIV_LAST) begin
          div_n  = '0;
          sreg_n = {sreg_q[6:0], 1'b0};
          bit_n  = bit_q - 3'd1;
          if (bit_q == 3'd0) begin
            if (state_q == SHIFT) begin
              cnt_n   = cnt_q - LEN_W'(1);
              state_n = (cnt_q == LEN_W'(1)) ? LATCH : LOAD;
            end else begin
              state_n = FIN;
            end
          end
        end else begin
          div_n = div_q + DW'(1);
        end
      end
      LATCH: begin
        sreg_n  = CRC_IN;
        bit_n   = 3'd7;
        div_n   = '0;
        state_n = CSHIFT;
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Outputs are decoded from next-state values so they can be registered without a cycle of lag.
    din_ready_n   = (state_n == LOAD);
    tx_valid_n    = (state_n == SHIFT) || (state_n == CSHIFT);
    txd_n         = tx_valid_n && sreg_n[7];
    crc_enable_n  = (state_n == SHIFT);
    crc_bitval_n  = crc_enable_n && sreg_n[7];
    crc_bitstrb_n = crc_enable_n && (div_n >= DIV_HALF);
    crc_clear_n   = (state_n == CLR);
    busy_n        = (state_n != IDLE);
    done_n        = (state_n == FIN);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      cnt_q       <= '0;
      sreg_q      <= '0;
      DIN_READY   <= 1'b0;
      CRC_BITVAL  <= 1'b0;
      CRC_BITSTRB <= 1'b0;
      CRC_ENABLE  <= 1'b0;
      CRC_CLEAR   <= 1'b0;
      TXD         <= 1'b0;
      TX_VALID    <= 1'b0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
    end else begin
      state_q     <= state_n;
      div_q       <= div_n;
      bit_q       <= bit_n;
      cnt_q       <= cnt_n;
      sreg_q      <= sreg_n;
      DIN_READY   <= din_ready_n;
      CRC_BITVAL  <= crc_bitval_n;
      CRC_BITSTRB <= crc_bitstrb_n;
      CRC_ENABLE  <= crc_enable_n;
      CRC_CLEAR   <= crc_clear_n;
      TXD         <= txd_n;
      TX_VALID    <= tx_valid_n;
      BUSY        <= busy_n;
      DONE        <= done_n;
    end
  end

`ifdef CRC8SER_SELFCHECK_EN
  logic [7:0] shadow_q;
  logic       err_q;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
  endfunction

  // Shadow advances once per payload bit, on the last clock of the bit period.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shadow_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == CLR)
        shadow_q <= '0;
      else if (state_q == SHIFT && div_q == DIV_LAST)
        shadow_q <= crc8_step(shadow_q, sreg_q[7]);
      if (state_q == IDLE && START)
        err_q <= 1'b0;
      else if (state_q == LATCH && shadow_q != CRC_IN)
        err_q <= 1'b1;
    end
  end

  assign CRC_ERR = err_q;
`else
  assign CRC_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_crc8_frame_serializer.sv
// Randomized frames against a polynomial-division CRC reference; includes a stand-in CRC-8 engine.
module tb_crc8_frame_serializer;
  localparam int LEN_W   = 8;
  localparam int BIT_DIV = 4;
  localparam int LIM     = 3000;

  typedef logic [7:0] bq_t[$];

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             START = 1'b0;
  logic [LEN_W-1:0] LEN = '0;
  logic [7:0]       DIN = '0;
  logic             DIN_VALID = 1'b0;
  logic             DIN_READY;
  logic [7:0]       CRC_IN;
  logic             CRC_BITVAL, CRC_BITSTRB, CRC_ENABLE, CRC_CLEAR;
  logic             TXD, TX_VALID, BUSY, DONE, CRC_ERR;

  crc8_frame_serializer #(.LEN_W(LEN_W), .BIT_DIV(BIT_DIV)) dut (
    .CLK(CLK), .RST(RST), .START(START), .LEN(LEN), .DIN(DIN),
    .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY), .CRC_IN(CRC_IN),
    .CRC_BITVAL(CRC_BITVAL), .CRC_BITSTRB(CRC_BITSTRB), .CRC_ENABLE(CRC_ENABLE),
    .CRC_CLEAR(CRC_CLEAR), .TXD(TXD), .TX_VALID(TX_VALID), .BUSY(BUSY),
    .DONE(DONE), .CRC_ERR(CRC_ERR)
  );

  always #5 CLK = ~CLK;

  // Stand-in for the external bit-serial engine.
  logic [7:0] eng = 8'h00;
  logic       eng_strb_d = 1'b0;
  logic       crc_force = 1'b0;
  logic [7:0] crc_forced = 8'h00;
  assign CRC_IN = crc_force ? crc_forced : eng;

  always @(posedge CLK) begin
    if (CRC_CLEAR) eng <= 8'h00;
    else if (CRC_ENABLE && CRC_BITSTRB && !eng_strb_d)
      eng <= {eng[6:0], 1'b0} ^ ((eng[7] ^ CRC_BITVAL) ? 8'h07 : 8'h00);
    eng_strb_d <= CRC_BITSTRB;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: remainder of (message * x^8) divided by x^8+x^2+x+1, by long division.
  function automatic logic [7:0] ref_crc(input bq_t d);
    bit m[$];
    logic [8:0] poly;
    logic [7:0] r;
    poly = 9'h107;
    foreach (d[k]) for (int b = 7; b >= 0; b--) m.push_back(d[k][b]);
    for (int b = 0; b < 8; b++) m.push_back(1'b0);
    for (int i = 0; i < d.size() * 8; i++)
      if (m[i]) for (int j = 0; j < 9; j++) m[i+j] = m[i+j] ^ poly[8-j];
    r = 8'h00;
    for (int j = 0; j < 8; j++) r = {r[6:0], m[d.size()*8 + j]};
    return r;
  endfunction

  // Line monitor, sampled on the falling edge.
  bit rx_bits[$];
  int vcnt, stab_err, strb_rise, done_cnt, clr_cnt, rdy_seen;
  logic cur_bit = 1'b0;
  logic mon_strb_d = 1'b0;

  task automatic mon_clear();
    rx_bits.delete();
    vcnt = 0; stab_err = 0; strb_rise = 0; done_cnt = 0; clr_cnt = 0; rdy_seen = 0;
  endtask

  always @(negedge CLK) begin
    if (TX_VALID) begin
      if (vcnt % BIT_DIV == 0) begin
        rx_bits.push_back(TXD);
        cur_bit = TXD;
      end else if (TXD !== cur_bit) stab_err++;
      vcnt++;
    end
    if (CRC_BITSTRB && !mon_strb_d) strb_rise++;
    mon_strb_d = CRC_BITSTRB;
    if (CRC_BITSTRB && !(CRC_ENABLE && TX_VALID)) stab_err++;
    if (CRC_ENABLE && (CRC_BITVAL !== TXD)) stab_err++;
    done_cnt += int'(DONE);
    clr_cnt  += int'(CRC_CLEAR);
    if (DIN_READY) rdy_seen = 1;
  end

  task automatic wait_ready(inout int tmo);
    int t;
    t = 0;
    while (!DIN_READY && t < LIM) begin @(negedge CLK); t++; end
    if (t >= LIM) tmo++;
  endtask

  task automatic run_frame(input int len, input bq_t pl, input int gap_idx, input int gap_len,
                           input bit poke, output logic [7:0] crc_got);
    int tmo, gap_bad, t;
    bq_t exp;
    logic [7:0] exp_crc, b;
    tmo = 0; gap_bad = 0;
    mon_clear();
    @(negedge CLK);
    START = 1'b1; LEN = LEN_W'(len);
    @(negedge CLK);
    START = 1'b0; LEN = LEN_W'($urandom);
    for (int k = 0; k < len; k++) begin
      if (k == gap_idx) begin
        wait_ready(tmo);
        for (int g = 0; g < gap_len; g++) begin
          if (TX_VALID || CRC_BITSTRB || TXD) gap_bad++;
          @(negedge CLK);
        end
      end
      DIN = pl[k]; DIN_VALID = 1'b1;
      wait_ready(tmo);
      @(negedge CLK);
      DIN_VALID = 1'b0; DIN = 8'($urandom);
      if (poke && k == 0) begin
        START = 1'b1; LEN = LEN_W'($urandom);
        @(negedge CLK);
        START = 1'b0;
      end
    end
    t = 0;
    while (!DONE && t < LIM) begin @(negedge CLK); t++; end
    if (t >= LIM) tmo++;
    repeat (2) @(negedge CLK);

    exp = pl;
    exp_crc = crc_force ? crc_forced : ref_crc(pl);
    exp.push_back(exp_crc);
    check("timeout", tmo, 0);
    check("nbits", rx_bits.size(), (len + 1) * 8);
    check("valid_clks", vcnt, (len + 1) * 8 * BIT_DIV);
    check("strobes", strb_rise, len * 8);
    check("done_cnt", done_cnt, 1);
    check("clear_cnt", clr_cnt, 1);
    check("ready_seen", rdy_seen, (len > 0) ? 1 : 0);
    check("bit_timing", stab_err, 0);
    check("gap_quiet", gap_bad, 0);
    check("busy_end", BUSY, 0);
`ifdef CRC8SER_SELFCHECK_EN
    check("crc_err", CRC_ERR, (crc_force && crc_forced != ref_crc(pl)) ? 1 : 0);
`else
    check("crc_err", CRC_ERR, 0);
`endif
    crc_got = 8'hxx;
    if (rx_bits.size() >= (len + 1) * 8) begin
      for (int k = 0; k <= len; k++) begin
        b = 8'h00;
        for (int j = 0; j < 8; j++) b = {b[6:0], rx_bits[k*8 + j]};
        check((k == len) ? "crc_byte" : "data_byte", b, exp[k]);
        if (k == len) crc_got = b;
      end
    end
  endtask

  function automatic logic [9:0] outs();
    return {DIN_READY, CRC_BITVAL, CRC_BITSTRB, CRC_ENABLE, CRC_CLEAR,
            TXD, TX_VALID, BUSY, DONE, CRC_ERR};
  endfunction

  initial begin
    bq_t q;
    logic [7:0] c;
    int len, tmo;

    repeat (3) @(negedge CLK);
    check("reset_outs", outs(), 0);
    RST = 1'b0;
    @(negedge CLK);
    check("idle_outs", outs(), 0);

    q = '{8'h01};
    run_frame(1, q, -1, 0, 0, c);  check("crc_01", c, 8'h07);
    q = '{8'hFF};
    run_frame(1, q, -1, 0, 0, c);  check("crc_ff", c, 8'hF3);
    q = '{8'h00};
    run_frame(1, q, -1, 0, 0, c);  check("crc_00", c, 8'h00);
    q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    run_frame(9, q, 3, 5, 0, c);   check("crc_check", c, 8'hF4);
    q = {};
    run_frame(0, q, -1, 0, 0, c);  check("crc_len0", c, 8'h00);

    // Reset while the second byte is being shifted.
    tmo = 0;
    mon_clear();
    @(negedge CLK);
    START = 1'b1; LEN = 8'd3;
    @(negedge CLK);
    START = 1'b0;
    for (int k = 0; k < 2; k++) begin
      DIN = 8'hA5 + 8'(k); DIN_VALID = 1'b1;
      wait_ready(tmo);
      @(negedge CLK);
      DIN_VALID = 1'b0;
    end
    repeat (5) @(negedge CLK);
    check("pre_rst_valid", TX_VALID, 1);
    RST = 1'b1;
    #1;
    check("midrst_outs", outs(), 0);
    check("midrst_tmo", tmo, 0);
    @(negedge CLK);
    RST = 1'b0;
    q = '{8'h01};
    run_frame(1, q, -1, 0, 1, c);  check("crc_after_rst", c, 8'h07);

    for (int n = 0; n < 20; n++) begin
      len = $urandom_range(0, 6);
      q = {};
      for (int k = 0; k < len; k++) q.push_back(8'($urandom));
      run_frame(len, q, $urandom_range(0, 6), $urandom_range(0, 6), 1'($urandom), c);
    end

`ifdef CRC8SER_SELFCHECK_EN
    crc_force = 1'b1; crc_forced = 8'h00;
    q = '{8'h01};
    run_frame(1, q, -1, 0, 0, c);
    crc_force = 1'b0;
    run_frame(1, q, -1, 0, 0, c);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
